// File: rtl/button_event_ctrl_if.sv
// Event pop port of button_event_ctrl: FIFO head with valid/ready handshake.
// master = event producer (controller), slave = consumer (CPU side).
interface button_event_ctrl_if #(
    parameter int DW = 4
) ();
    logic          evt_valid;
    logic [DW-1:0] evt_data;
    logic          evt_ready;

    modport master (output evt_valid, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_data, output evt_ready);
endinterface

// File: rtl/button_event_ctrl.sv
// Per-button press/long/repeat FSMs feeding a round-robin arbitrated event FIFO.
// Optional macro REPEAT_EN enables periodic REPEAT events while a button is held.
module button_event_ctrl #(
    parameter int N_BTN         = 4,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          clr,
    input  logic [N_BTN-1:0]              btn_state,
    input  logic [N_BTN-1:0]              btn_down,
    input  logic [N_BTN-1:0]              btn_up,
    button_event_ctrl_if.master           evt,
    output logic                          irq,
    output logic                          ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int IDXW = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam int DW   = 2 + IDXW;
    localparam int MAXC = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [1:0]    T_PRESS   = 2'd0;
    localparam logic [1:0]    T_RELEASE = 2'd1;
    localparam logic [1:0]    T_LONG    = 2'd2;
    localparam logic [1:0]    T_REPEAT  = 2'd3;
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
`ifdef REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} state_e;

    state_e        st_q  [N_BTN];
    state_e        st_d  [N_BTN];
    logic [CW-1:0] cnt_q [N_BTN];
    logic [CW-1:0] cnt_d [N_BTN];
    logic [3:0]    emit  [N_BTN];
    logic [3:0]    pend_q[N_BTN];
    logic [3:0]    pend_d[N_BTN];
    logic [3:0]    gmask [N_BTN];

    logic            gnt;
    logic [IDXW-1:0] gidx;
    logic [1:0]      gtype;
    logic [IDXW-1:0] rr_q, rr_d;
    logic            ovf_q, drop;

    logic [DW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     count_q, count_d;
    logic            full, pop, push, head_valid;

    // Button FSM next-state; priority: disable, down, up, silent drop of level, timers
    always_comb begin
        for (int unsigned i = 0; i < N_BTN; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            emit[i]  = '0;
            if (!en) begin
                st_d[i]  = S_IDLE;
                cnt_d[i] = '0;
            end else if (btn_down[i]) begin
                emit[i][T_PRESS] = 1'b1;
                cnt_d[i]         = '0;
                st_d[i]          = S_PRESSED;
            end else if (st_q[i] != S_IDLE && btn_up[i]) begin
                emit[i][T_RELEASE] = 1'b1;
                cnt_d[i]           = '0;
                st_d[i]            = S_IDLE;
            end else if (st_q[i] != S_IDLE && !btn_state[i]) begin
                cnt_d[i] = '0;
                st_d[i]  = S_IDLE;
            end else begin
                case (st_q[i])
                    S_PRESSED: begin
                        if (cnt_q[i] == LONG_LAST) begin
                            emit[i][T_LONG] = 1'b1;
                            cnt_d[i]        = '0;
                            st_d[i]         = S_HELD;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                    S_HELD: begin
`ifdef REPEAT_EN
                        if (cnt_q[i] == REP_LAST) begin
                            emit[i][T_REPEAT] = 1'b1;
                            cnt_d[i]          = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
`else
                        cnt_d[i] = '0;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                st_q[i]  <= S_IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign head_valid = (count_q != '0);
    assign full       = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop        = head_valid & evt.evt_ready;
    assign push       = gnt;

    // Round-robin over buttons, fixed type priority PRESS > LONG > REPEAT > RELEASE
    always_comb begin
        int unsigned idx;
        idx   = 0;
        gnt   = 1'b0;
        gidx  = '0;
        gtype = T_PRESS;
        for (int unsigned i = 0; i < N_BTN; i++) gmask[i] = '0;
        if (!full || pop) begin
            for (int unsigned k = 0; k < N_BTN; k++) begin
                idx = 32'(rr_q) + k;
                if (idx >= N_BTN) idx = idx - N_BTN;
                if (!gnt && pend_q[idx] != '0) begin
                    gnt  = 1'b1;
                    gidx = IDXW'(idx);
                    if (pend_q[idx][T_PRESS])       gtype = T_PRESS;
                    else if (pend_q[idx][T_LONG])   gtype = T_LONG;
`ifdef REPEAT_EN
                    else if (pend_q[idx][T_REPEAT]) gtype = T_REPEAT;
`endif
                    else                            gtype = T_RELEASE;
                    gmask[idx][gtype] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        drop = 1'b0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            pend_d[i] = (pend_q[i] & ~gmask[i]) | emit[i];
            drop      = drop | (|(emit[i] & pend_q[i] & ~gmask[i]));
`ifndef REPEAT_EN
            pend_d[i][T_REPEAT] = 1'b0;
`endif
        end
        rr_d = rr_q;
        if (gnt) rr_d = (gidx == IDXW'(N_BTN - 1)) ? '0 : gidx + IDXW'(1);
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // clr outranks any same-cycle emit, grant, push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_BTN; i++) pend_q[i] <= '0;
            ovf_q   <= 1'b0;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clr) begin
            for (int unsigned i = 0; i < N_BTN; i++) pend_q[i] <= '0;
            ovf_q   <= 1'b0;
            rr_q    <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) pend_q[i] <= pend_d[i];
            ovf_q   <= ovf_q | drop;
            rr_q    <= rr_d;
            wr_q    <= wr_q + AW'(push);
            rd_q    <= rd_q + AW'(pop);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_q] <= {gtype, gidx};
    end

    assign evt.evt_valid = head_valid;
    assign evt.evt_data  = head_valid ? mem_q[rd_q] : '0;
    assign irq           = head_valid & en;
    assign ovf           = ovf_q;
    assign fifo_count    = count_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: stimulus pushes expected events, a
// negedge monitor pops and compares every accepted FIFO head.
module tb_button_event_ctrl;

    localparam int N     = 4;
    localparam int LONG  = 8;
    localparam int REP   = 4;
    localparam int DEPTH = 2;
    localparam int DW    = 4;

    logic         clk = 1'b0;
    logic         rst_n, en, clr, ready;
    logic [N-1:0] btn_state, btn_down, btn_up;
    logic         irq, ovf;
    logic [1:0]   fifo_count;

    logic [DW-1:0] sbq[$];
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    button_event_ctrl_if #(.DW(DW)) evt_if ();
    assign evt_if.evt_ready = ready;

    button_event_ctrl #(
        .N_BTN(N), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .FIFO_DEPTH(DEPTH)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .btn_state(btn_state), .btn_down(btn_down), .btn_up(btn_up),
        .evt(evt_if), .irq(irq), .ovf(ovf), .fifo_count(fifo_count)
    );

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [DW-1:0] ev(logic [1:0] t, int idx);
        logic [1:0] ix;
        ix = idx[1:0];
        return {t, ix};
    endfunction

    always @(negedge clk) begin
        if (rst_n && evt_if.evt_valid && ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_event: got %0h expected none", evt_if.evt_data);
            end else begin
                chk("event", 32'(evt_if.evt_data), 32'(sbq.pop_front()));
            end
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(string name);
        for (int k = 0; k < 60 && (sbq.size() != 0 || evt_if.evt_valid); k++) step();
        chk(name, 32'(sbq.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; ready = 1'b0;
        btn_state = '0; btn_down = '0; btn_up = '0;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_valid", 32'(evt_if.evt_valid), 0);
        chk("rst_data",  32'(evt_if.evt_data), 0);
        chk("rst_irq",   32'(irq), 0);
        chk("rst_ovf",   32'(ovf), 0);
        chk("rst_count", 32'(fifo_count), 0);
        step();
        rst_n = 1'b1; en = 1'b1; ready = 1'b1;
        step(2);

        // Press/release of button 2, latency of two cycles
        btn_state[2] = 1'b1; btn_down = 4'b0100;
        sbq.push_back(ev(2'd0, 2));
        step(); btn_down = '0;
        chk("A_valid_t1", 32'(evt_if.evt_valid), 0);
        step();
        chk("A_valid_t2", 32'(evt_if.evt_valid), 1);
        chk("A_data_t2",  32'(evt_if.evt_data), 32'(ev(2'd0, 2)));
        step(3);
        btn_up = 4'b0100; btn_state[2] = 1'b0;
        sbq.push_back(ev(2'd1, 2));
        step(); btn_up = '0;
        drain("A_drain");

        // Long hold on button 0, released at t+20
        btn_state[0] = 1'b1; btn_down = 4'b0001;
        sbq.push_back(ev(2'd0, 0));
        step(); btn_down = '0;
        sbq.push_back(ev(2'd2, 0));
`ifdef REPEAT_EN
        sbq.push_back(ev(2'd3, 0));
        sbq.push_back(ev(2'd3, 0));
`endif
        sbq.push_back(ev(2'd1, 0));
        step(8);
        chk("B_valid_t9", 32'(evt_if.evt_valid), 0);
        step();
        chk("B_valid_t10", 32'(evt_if.evt_valid), 1);
        chk("B_long_t10",  32'(evt_if.evt_data), 32'(ev(2'd2, 0)));
        step(10);
        btn_up = 4'b0001; btn_state[0] = 1'b0;
        step(); btn_up = '0;
        drain("B_drain");
        chk("B_ovf", 32'(ovf), 0);

        // Round-robin ordering and wrap
        clr = 1'b1; step(); clr = 1'b0;
        btn_state = 4'b1011; btn_down = 4'b1011;
        sbq.push_back(ev(2'd0, 0)); sbq.push_back(ev(2'd0, 1)); sbq.push_back(ev(2'd0, 3));
        step(); btn_down = '0;
        step(2);
        btn_down = 4'b0011;
        sbq.push_back(ev(2'd0, 0)); sbq.push_back(ev(2'd0, 1));
        step(); btn_down = '0;
        step(2);
        btn_up = 4'b1011; btn_state = '0;
        sbq.push_back(ev(2'd1, 3)); sbq.push_back(ev(2'd1, 0)); sbq.push_back(ev(2'd1, 1));
        step(); btn_up = '0;
        drain("C_drain");

        // Stalled FIFO, overflow on a repeated pending bit, push+pop while full
        clr = 1'b1; step(); clr = 1'b0;
        ready = 1'b0;
        btn_state[0] = 1'b1; btn_down = 4'b0001; sbq.push_back(ev(2'd0, 0));
        step(); btn_down = '0;
        btn_up = 4'b0001; btn_state[0] = 1'b0; sbq.push_back(ev(2'd1, 0));
        step(); btn_up = '0;
        btn_state[1] = 1'b1; btn_down = 4'b0010; sbq.push_back(ev(2'd0, 1));
        step(); btn_down = '0;
        btn_up = 4'b0010; btn_state[1] = 1'b0; sbq.push_back(ev(2'd1, 1));
        step(); btn_up = '0;
        btn_state[1] = 1'b1; btn_down = 4'b0010;
        step(); btn_down = '0; btn_state[1] = 1'b0;
        chk("D_count_full", 32'(fifo_count), 2);
        chk("D_ovf", 32'(ovf), 1);
        ready = 1'b1;
        step();
        chk("D_count_pushpop", 32'(fifo_count), 2);
        drain("D_drain");

        // clr with three queued events, then reset while held
        ready = 1'b0;
        btn_state = 4'b0111; btn_down = 4'b0111;
        step(); btn_down = '0;
        step(2);
        chk("E_count", 32'(fifo_count), 2);
        chk("E_irq", 32'(irq), 1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("E_clr_valid", 32'(evt_if.evt_valid), 0);
        chk("E_clr_ovf",   32'(ovf), 0);
        chk("E_clr_count", 32'(fifo_count), 0);
        step(2);
        chk("E_no_pending", 32'(evt_if.evt_valid), 0);
        for (int k = 0; k < 20 && !evt_if.evt_valid; k++) step();
        chk("E_long_seen", 32'(evt_if.evt_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("R_valid", 32'(evt_if.evt_valid), 0);
        chk("R_data",  32'(evt_if.evt_data), 0);
        chk("R_irq",   32'(irq), 0);
        chk("R_count", 32'(fifo_count), 0);
        step(2);
        rst_n = 1'b1;
        step(5);
        chk("R_no_event", 32'(fifo_count), 0);
        btn_state = '0;
        step();

        // en=0 masks irq, skips RELEASE, still drains queued events
        btn_state[3] = 1'b1; btn_down = 4'b1000; sbq.push_back(ev(2'd0, 3));
        step(); btn_down = '0; en = 1'b0;
        step(2);
        chk("F_valid", 32'(evt_if.evt_valid), 1);
        chk("F_irq_masked", 32'(irq), 0);
        btn_up = 4'b1000; btn_state[3] = 1'b0;
        step(); btn_up = '0;
        step();
        ready = 1'b1;
        drain("F_drain");
        chk("F_count", 32'(fifo_count), 0);
        en = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
